// File: rtl/instr_boot_loader.sv
// -----------------------------------------------------------------------------
// instr_boot_loader
//
// Streams a program image from a host into instruction memory, then holds the
// processor core in reset for a fixed settling time before releasing it.
//
//   IDLE : core held in reset, waiting for start
//   LOAD : accepting words on in_data/in_valid, one imem write per word
//   HOLD : all words written, core still in reset for RELEASE_DELAY cycles
//   RUN  : core released; reload returns to IDLE
//
// Ports
//   clk, resetn             clock, asynchronous active-low reset
//   start, base_addr,       session request and its parameters (IDLE only)
//   word_count
//   in_data, in_valid,      host word stream; a word moves on in_valid&in_ready
//   in_ready
//   reload                  in RUN, put the core back in reset and go to IDLE
//   boot_iaddr, boot_idata, imem write port (word address, data, strobe)
//   boot_iwe
//   core_resetn             active-low reset to the core, high only in RUN
//   busy                    high in LOAD and HOLD
//   err                     sticky: a start would have run past the memory end
// -----------------------------------------------------------------------------
module instr_boot_loader #(
    parameter int I_ADDRESSWIDTH = 14,
    parameter int I_SIZE         = 16384,
    parameter int RELEASE_DELAY  = 4
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      start,
    input  logic [I_ADDRESSWIDTH-1:0] base_addr,
    input  logic [I_ADDRESSWIDTH:0]   word_count,
    input  logic [31:0]               in_data,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      reload,
    output logic [31:0]               boot_iaddr,
    output logic [31:0]               boot_idata,
    output logic                      boot_iwe,
    output logic                      core_resetn,
    output logic                      busy,
    output logic                      err
);

    localparam int AW = I_ADDRESSWIDTH;
    // One extra bit beyond word_count so base_addr + word_count never wraps.
    localparam int SW = AW + 2;
    localparam logic [SW-1:0] SIZE_LIMIT = SW'(I_SIZE);
    localparam logic [AW:0]   IDX_ONE    = (AW+1)'(1);
    localparam logic [7:0]    HOLD_LOAD  = 8'(RELEASE_DELAY - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_HOLD,
        S_RUN
    } state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   base_q, base_d;
    logic [AW:0]     count_q, count_d;
    logic [AW:0]     index_q, index_d;
    logic [7:0]      hold_q, hold_d;
    logic            in_ready_q, in_ready_d;
    logic            iwe_q, iwe_d;
    logic [31:0]     iaddr_q, iaddr_d;
    logic [31:0]     idata_q, idata_d;
    logic            core_resetn_q, core_resetn_d;
    logic            busy_q, busy_d;
    logic            err_q, err_d;

    logic [SW-1:0]   end_addr;
    logic            start_overflow;
    logic [AW-1:0]   wr_addr;
    logic            last_word;

    assign end_addr       = SW'(base_addr) + SW'(word_count);
    assign start_overflow = end_addr > SIZE_LIMIT;
    assign wr_addr        = base_q + index_q[AW-1:0];
    assign last_word      = index_q == (count_q - IDX_ONE);

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        state_d = state_q;
        base_d  = base_q;
        count_d = count_q;
        index_d = index_q;
        hold_d  = hold_q;
        iwe_d   = 1'b0;
        iaddr_d = iaddr_q;
        idata_d = idata_q;
        err_d   = err_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (start_overflow) begin
                        err_d = 1'b1;
                    end else if (word_count == '0) begin
                        err_d   = 1'b0;
                        hold_d  = HOLD_LOAD;
                        state_d = S_HOLD;
                    end else begin
                        err_d   = 1'b0;
                        base_d  = base_addr;
                        count_d = word_count;
                        index_d = '0;
                        state_d = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                if (in_valid && in_ready_q) begin
                    iwe_d   = 1'b1;
                    idata_d = in_data;
                    iaddr_d = 32'(wr_addr);
                    index_d = index_q + IDX_ONE;
                    if (last_word) begin
                        hold_d  = HOLD_LOAD;
                        state_d = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                // Loaded with RELEASE_DELAY-1 so HOLD spans RELEASE_DELAY cycles.
                if (hold_q == 8'd0) begin
                    state_d = S_RUN;
                end else begin
                    hold_d = hold_q - 8'd1;
                end
            end
            S_RUN: begin
                if (reload) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Status outputs are registered images of the next state.
        in_ready_d    = state_d == S_LOAD;
        core_resetn_d = state_d == S_RUN;
        busy_d        = (state_d == S_LOAD) || (state_d == S_HOLD);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops sample
    // the same pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= S_IDLE;
            base_q        <= '0;
            count_q       <= '0;
            index_q       <= '0;
            hold_q        <= '0;
            in_ready_q    <= 1'b0;
            iwe_q         <= 1'b0;
            iaddr_q       <= '0;
            idata_q       <= '0;
            core_resetn_q <= 1'b0;
            busy_q        <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            base_q        <= base_d;
            count_q       <= count_d;
            index_q       <= index_d;
            hold_q        <= hold_d;
            in_ready_q    <= in_ready_d;
            iwe_q         <= iwe_d;
            iaddr_q       <= iaddr_d;
            idata_q       <= idata_d;
            core_resetn_q <= core_resetn_d;
            busy_q        <= busy_d;
            err_q         <= err_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign boot_iwe    = iwe_q;
    assign boot_iaddr  = iaddr_q;
    assign boot_idata  = idata_q;
    assign core_resetn = core_resetn_q;
    assign busy        = busy_q;
    assign err         = err_q;

endmodule

// File: tb/tb_instr_boot_loader.sv
// -----------------------------------------------------------------------------
// tb_instr_boot_loader
//
// The whole run is planned up front as a per-cycle table: stimulus for every
// cycle and the outputs that must be seen in that cycle. Expected outputs are
// derived from session-level timing (LOAD from start+1 to the last transfer,
// HOLD for RELEASE_DELAY cycles after it, RUN afterwards), with later events
// (reload, reset) overriding the tail of the table. A compare process checks
// every output on every falling edge; a log of observed writes is checked
// against hand-computed literals at the end.
// -----------------------------------------------------------------------------
module tb_instr_boot_loader;

    localparam int AW   = 14;
    localparam int RD   = 4;
    localparam int NCYC = 96;

    localparam logic [31:0] W_A = 32'hAAAA_0001;
    localparam logic [31:0] W_B = 32'hBBBB_0002;
    localparam logic [31:0] W_C = 32'hCCCC_0003;
    localparam logic [31:0] W_D = 32'hD0D0_0004;
    localparam logic [31:0] W_E = 32'hE0E0_0005;
    localparam logic [31:0] W_F = 32'hF0F0_0006;

    logic          clk = 1'b0;
    logic          resetn;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW:0]   word_count;
    logic [31:0]   in_data;
    logic          in_valid;
    logic          in_ready;
    logic          reload;
    logic [31:0]   boot_iaddr;
    logic [31:0]   boot_idata;
    logic          boot_iwe;
    logic          core_resetn;
    logic          busy;
    logic          err;

    always #5 clk = ~clk;

    instr_boot_loader #(
        .I_ADDRESSWIDTH(AW),
        .I_SIZE        (16384),
        .RELEASE_DELAY (RD)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .start      (start),
        .base_addr  (base_addr),
        .word_count (word_count),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .reload     (reload),
        .boot_iaddr (boot_iaddr),
        .boot_idata (boot_idata),
        .boot_iwe   (boot_iwe),
        .core_resetn(core_resetn),
        .busy       (busy),
        .err        (err)
    );

    typedef struct packed {
        logic        in_ready;
        logic        busy;
        logic        core_resetn;
        logic        iwe;
        logic        err;
        logic [31:0] iaddr;
        logic [31:0] idata;
    } exp_t;

    typedef struct {
        int          cyc;
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    exp_t          exp_tab   [NCYC];
    logic          st_resetn [NCYC];
    logic          st_start  [NCYC];
    logic          st_valid  [NCYC];
    logic          st_reload [NCYC];
    logic [AW-1:0] st_base   [NCYC];
    logic [AW:0]   st_wc     [NCYC];
    logic [31:0]   st_data   [NCYC];

    wr_t wlog[$];
    int  cyc    = 0;
    bit  active = 1'b0;
    int  n_checks = 0;
    int  n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_checks++;
        if (act === want) n_pass++;
        else $display("FAIL %s: got %h, want %h", name, act, want);
    endtask

    // ---------------------------------------------------------------- planning
    function automatic void plan_init();
        for (int i = 0; i < NCYC; i++) begin
            exp_tab[i]   = '0;
            st_resetn[i] = 1'b1;
            st_start[i]  = 1'b0;
            st_valid[i]  = 1'b0;
            st_reload[i] = 1'b0;
            st_base[i]   = '0;
            st_wc[i]     = '0;
            st_data[i]   = '0;
        end
    endfunction

    // Legal session: start driven in cycle s; pat gives in_valid for the LOAD
    // cycles (ones after it runs out). A word presented with in_valid is
    // written in the next cycle at base+j. After the last transfer the host
    // keeps offering a spare word, which must not be taken.
    function automatic void plan_session(input int s, input logic [AW-1:0] base, input int n,
                                         input logic [31:0] words[$], input bit pat[$]);
        int c = s;
        int j = 0;
        int k = 0;
        int t_last;
        st_start[s] = 1'b1;
        st_base[s]  = base;
        st_wc[s]    = (AW+1)'(n);
        while (j < n && c < NCYC - 2) begin
            bit v;
            c++;
            v = (k < pat.size()) ? pat[k] : 1'b1;
            k++;
            st_valid[c] = v;
            if (v) begin
                st_data[c] = words[j];
                exp_tab[c+1].iwe = 1'b1;
                for (int i = c + 1; i < NCYC; i++) begin
                    exp_tab[i].iaddr = 32'(base) + 32'(j);
                    exp_tab[i].idata = words[j];
                end
                j++;
            end else begin
                st_data[c] = 32'hBAD0_0000 | 32'(c);
            end
        end
        t_last = c;
        if (n > 0 && t_last + 1 < NCYC) begin
            st_valid[t_last+1] = 1'b1;
            st_data[t_last+1]  = 32'hE7E7_E7E7;
        end
        for (int i = s + 1; i < NCYC; i++) begin
            exp_tab[i].in_ready    = i <= t_last;
            exp_tab[i].busy        = i <= t_last + RD;
            exp_tab[i].core_resetn = i > t_last + RD;
            exp_tab[i].err         = 1'b0;
        end
    endfunction

    function automatic void plan_illegal(input int s, input logic [AW-1:0] base, input int n);
        st_start[s] = 1'b1;
        st_base[s]  = base;
        st_wc[s]    = (AW+1)'(n);
        for (int i = s + 1; i < NCYC; i++) exp_tab[i].err = 1'b1;
    endfunction

    // Reload in RUN; optionally with a legal start alongside, which must lose.
    function automatic void plan_reload(input int c, input bit with_start);
        st_reload[c] = 1'b1;
        if (with_start) begin
            st_start[c] = 1'b1;
            st_base[c]  = 14'h0005;
            st_wc[c]    = 15'd2;
        end
        for (int i = c + 1; i < NCYC; i++) begin
            exp_tab[i].core_resetn = 1'b0;
            exp_tab[i].busy        = 1'b0;
            exp_tab[i].in_ready    = 1'b0;
        end
    endfunction

    // Asynchronous reset: outputs return to reset values in the same cycle.
    function automatic void plan_reset(input int c, input int dur);
        for (int i = c; i < c + dur && i < NCYC; i++) st_resetn[i] = 1'b0;
        for (int i = c; i < NCYC; i++) begin
            exp_tab[i]   = '0;
            st_start[i]  = 1'b0;
            st_valid[i]  = 1'b0;
            st_reload[i] = 1'b0;
        end
    endfunction

    function automatic void build_plan();
        logic [31:0] w[$];
        bit          p[$];
        plan_init();
        plan_reset(0, 3);

        // Three words back to back, then RUN after RD cycles of HOLD.
        w = {W_A, W_B, W_C};
        p.delete();
        plan_session(5, 14'h0010, 3, w, p);
        st_reload[7] = 1'b1;                                    // LOAD: ignored
        st_start[10] = 1'b1; st_wc[10] = 15'd1;                 // HOLD: ignored
        st_start[15] = 1'b1; st_wc[15] = 15'd1;                 // RUN: ignored
        plan_reload(17, 1'b0);

        // Same session with gaps in in_valid.
        w = {W_D, W_E, W_F};
        p = {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        plan_session(20, 14'h0010, 3, w, p);
        plan_reload(33, 1'b1);
        st_reload[36] = 1'b1;                                   // IDLE: ignored

        // Overflowing starts, then a legal one ending exactly at the top word.
        plan_illegal(38, 14'h3FFF, 2);
        plan_illegal(41, 14'h3FFE, 3);
        w = {32'h1234_5678, 32'h9ABC_DEF0};
        p.delete();
        plan_session(44, 14'h3FFE, 2, w, p);
        plan_reload(53, 1'b0);

        // Empty image: straight to HOLD.
        w.delete();
        plan_session(57, 14'h0020, 0, w, p);
        plan_reload(64, 1'b0);

        // Reset after two of five words.
        w = {32'h5000_0000, 32'h5000_0001, 32'h5000_0002, 32'h5000_0003, 32'h5000_0004};
        p = {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        plan_session(68, 14'h0100, 5, w, p);
        plan_reset(72, 3);

        // Reset clears err; loader still works afterwards.
        plan_illegal(77, 14'h3FFF, 2);
        plan_reset(80, 2);
        w = {32'h7777_7777};
        p.delete();
        plan_session(84, 14'h0000, 1, w, p);
    endfunction

    // ------------------------------------------------------------- compare
    always @(negedge clk) begin
        if (active) begin
            check($sformatf("in_ready@%0d", cyc),    32'(in_ready),    32'(exp_tab[cyc].in_ready));
            check($sformatf("busy@%0d", cyc),        32'(busy),        32'(exp_tab[cyc].busy));
            check($sformatf("core_resetn@%0d", cyc), 32'(core_resetn), 32'(exp_tab[cyc].core_resetn));
            check($sformatf("boot_iwe@%0d", cyc),    32'(boot_iwe),    32'(exp_tab[cyc].iwe));
            check($sformatf("err@%0d", cyc),         32'(err),         32'(exp_tab[cyc].err));
            check($sformatf("boot_iaddr@%0d", cyc),  boot_iaddr,       exp_tab[cyc].iaddr);
            check($sformatf("boot_idata@%0d", cyc),  boot_idata,       exp_tab[cyc].idata);
            if (boot_iwe === 1'b1) wlog.push_back('{cyc, boot_iaddr, boot_idata});
        end
    end

    task automatic check_write(input int idx, input int want_cyc,
                               input logic [31:0] want_addr, input logic [31:0] want_data);
        wr_t e = '{-1, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        if (idx < wlog.size()) e = wlog[idx];
        check($sformatf("write%0d.cycle", idx), 32'(e.cyc), 32'(want_cyc));
        check($sformatf("write%0d.addr", idx),  e.addr,     want_addr);
        check($sformatf("write%0d.data", idx),  e.data,     want_data);
    endtask

    // --------------------------------------------------------------- driver
    initial begin
        resetn     = 1'b0;
        start      = 1'b0;
        base_addr  = '0;
        word_count = '0;
        in_data    = '0;
        in_valid   = 1'b0;
        reload     = 1'b0;
        build_plan();

        // Pin the model to hand-derived timing of the first sessions.
        check("model.iaddr@7",        exp_tab[7].iaddr,               32'h0000_0010);
        check("model.idata@9",        exp_tab[9].idata,               W_C);
        check("model.core_resetn@12", 32'(exp_tab[12].core_resetn),   32'd0);
        check("model.core_resetn@13", 32'(exp_tab[13].core_resetn),   32'd1);
        check("model.in_ready@27",    32'(exp_tab[27].in_ready),      32'd0);
        check("model.busy@61",        32'(exp_tab[61].busy),          32'd1);
        check("model.busy@62",        32'(exp_tab[62].busy),          32'd0);
        check("model.err@39",         32'(exp_tab[39].err),           32'd1);
        check("model.err@45",         32'(exp_tab[45].err),           32'd0);

        for (int c = 0; c < NCYC; c++) begin
            @(posedge clk);
            #1;
            resetn     = st_resetn[c];
            start      = st_start[c];
            base_addr  = st_base[c];
            word_count = st_wc[c];
            in_data    = st_data[c];
            in_valid   = st_valid[c];
            reload     = st_reload[c];
            cyc        = c;
            active     = 1'b1;
        end
        @(negedge clk);
        #1;
        active = 1'b0;

        // Observed writes against hand-computed addresses, data and cycles.
        check("write_count", 32'(wlog.size()), 32'd11);
        check_write(0, 7,  32'h0000_0010, W_A);
        check_write(1, 8,  32'h0000_0011, W_B);
        check_write(2, 9,  32'h0000_0012, W_C);
        check_write(3, 22, 32'h0000_0010, W_D);
        check_write(4, 25, 32'h0000_0011, W_E);
        check_write(5, 27, 32'h0000_0012, W_F);
        check_write(6, 46, 32'h0000_3FFE, 32'h1234_5678);
        check_write(7, 47, 32'h0000_3FFF, 32'h9ABC_DEF0);
        check_write(8, 70, 32'h0000_0100, 32'h5000_0000);
        check_write(9, 71, 32'h0000_0101, 32'h5000_0001);
        check_write(10, 86, 32'h0000_0000, 32'h7777_7777);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/instr_boot_loader.md
INSTR_BOOT_LOADER -- requirements
Module: instr_boot_loader

Interface
REQ-001 Parameter I_ADDRESSWIDTH, default 14, instruction-memory word-address width.
REQ-002 Parameter I_SIZE, default 16384, instruction-memory depth in words.
REQ-003 Parameter RELEASE_DELAY, default 4, cycles between the last write and core reset release (range 1..255).
REQ-004 clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 resetn  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  begin a load session; sampled only in IDLE.
REQ-007 base_addr  input  I_ADDRESSWIDTH  first word address to write; sampled with start.
REQ-008 word_count  input  I_ADDRESSWIDTH+1  number of words to load; sampled with start.
REQ-009 in_data  input  32  instruction word from the host stream.
REQ-010 in_valid  input  1  in_data is valid.
REQ-011 in_ready  output  1  loader accepts in_data this cycle.
REQ-012 reload  input  1  in RUN, abort execution and return to IDLE.
REQ-013 boot_iaddr  output  32  imem write word address, zero-extended from I_ADDRESSWIDTH bits.
REQ-014 boot_idata  output  32  imem write data.
REQ-015 boot_iwe  output  1  imem write strobe, one cycle per word.
REQ-016 core_resetn  output  1  active-low reset to the processor core (fetch unit and pipeline).
REQ-017 busy  output  1  high in LOAD and HOLD.
REQ-018 err  output  1  sticky error: illegal start request.

Function
REQ-019 The FSM SHALL have states IDLE, LOAD, HOLD and RUN, all outputs registered.
REQ-020 In IDLE, start=1 with 1<=word_count and base_addr+word_count<=I_SIZE SHALL latch base_addr/word_count, clear the index counter and enter LOAD next cycle.
REQ-021 In IDLE, start=1 with word_count=0 SHALL enter HOLD directly with no writes.
REQ-022 In IDLE, start=1 with base_addr+word_count>I_SIZE (full-width sum, no wrap) SHALL set err and remain in IDLE.
REQ-023 err SHALL clear only on the next legal start or on reset.
REQ-024 in_ready SHALL equal 1 exactly while in LOAD; a word transfers on in_valid&in_ready.
REQ-025 Each transfer SHALL, on the following cycle, drive boot_iwe=1, boot_idata=in_data and boot_iaddr=latched base_addr+index, then increment index.
REQ-026 boot_iwe SHALL be 0 in every cycle not immediately following a transfer; boot_iaddr/boot_idata hold their last value when idle.
REQ-027 The transfer with index=word_count-1 SHALL move the FSM to HOLD; in_ready SHALL be 0 from that next cycle, so no extra word is accepted.
REQ-028 in_valid low in LOAD SHALL stall indefinitely with no writes and no timeout.
REQ-029 HOLD SHALL last exactly RELEASE_DELAY cycles, counted by a down-counter, then enter RUN.
REQ-030 core_resetn SHALL be 0 in IDLE, LOAD and HOLD, and 1 exactly while in RUN (first 1 on the cycle RUN is entered).
REQ-031 In RUN, start SHALL be ignored; reload=1 SHALL drive core_resetn to 0 on the next cycle and enter IDLE.
REQ-032 reload outside RUN SHALL be ignored; start and reload arriving together in RUN SHALL act as reload only.
REQ-033 A session loading the last memory word (base_addr+word_count=I_SIZE) SHALL be legal and write address I_SIZE-1 last.

Reset
REQ-034 resetn=0 SHALL immediately force state=IDLE, index=0, HOLD counter=0, in_ready=0, boot_iwe=0, boot_iaddr=0, boot_idata=0, core_resetn=0, busy=0, err=0.
REQ-035 Reset asserted mid-LOAD SHALL abort the session without issuing a further boot_iwe; the partial image is not preserved.
REQ-036 Reset deassertion SHALL not by itself start a session; start is required.

Verification
REQ-037 start, base_addr=0x10, word_count=3, words A,B,C with in_valid always high -> boot_iwe pulses at addresses 0x10,0x11,0x12 with A,B,C on 3 consecutive cycles; core_resetn rises RELEASE_DELAY cycles after the last pulse.
REQ-038 Same session with in_valid toggled 1,0,0,1,0,1 -> exactly 3 writes, in order, no write during gaps, in_ready low after the third transfer.
REQ-039 start, base_addr=0x3FFF, word_count=2 (defaults) -> err=1, state stays IDLE, no boot_iwe, core_resetn=0; a following legal start clears err.
REQ-040 start, word_count=0 -> no writes, busy high RELEASE_DELAY cycles, core_resetn=1 afterwards.
REQ-041 In RUN, assert reload together with start -> core_resetn=0 next cycle, state IDLE, no session started.
REQ-042 resetn pulsed low after 2 of 5 words -> all outputs at reset values immediately, no further boot_iwe, core_resetn stays 0.
